// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing so every datapath buffer agrees on word width and depth
package fifo_pkg;
    localparam int fifo_width = 8;
    localparam int fifo_depth = 8;
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: register array with one write port and one registered read port
module fifo_mem import fifo_pkg::*; #(
    parameter int width  = fifo_width,
    parameter int depth  = fifo_depth,
    parameter int addr_w = $clog2(depth)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [addr_w-1:0] i_waddr,
    input  logic [width-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [addr_w-1:0] i_raddr,
    output logic [width-1:0]  o_rdata
);
    logic [width-1:0] r_mem [depth];
    logic [width-1:0] r_rdata;
    assign o_rdata = r_rdata;
    // storage is never cleared; only accepted writes touch it
    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;
    // read register clears on reset and holds unless a read is accepted
    always_ff @(posedge clk or posedge rst)
        if (rst) r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
endmodule

// File: rtl/fifo.sv
// fifo: single-clock elastic buffer with registered read data and full/empty flags
module fifo import fifo_pkg::*; #(
    parameter int width = fifo_width,
    parameter int depth = fifo_depth
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [width-1:0] data_in,
    output logic [width-1:0] data_out,
    output logic             full,
    output logic             empty
);
    localparam int addr_w = $clog2(depth);
    logic [addr_w-1:0] r_wr_ptr, r_rd_ptr;
    logic [addr_w:0]   r_count, w_count_nxt;
    logic              r_full, r_empty, w_wr_acc, w_rd_acc;
    // a read frees a slot, so a write into a full buffer is legal alongside a read
    assign w_rd_acc = rd_en && !r_empty;
    assign w_wr_acc = wr_en && (!r_full || w_rd_acc);
    assign full     = r_full;
    assign empty    = r_empty;
    // occupancy moves only when exactly one side is accepted
    always_comb
        w_count_nxt = (w_wr_acc && !w_rd_acc) ? r_count + (addr_w+1)'(1) :
                      (!w_wr_acc && w_rd_acc) ? r_count - (addr_w+1)'(1) : r_count;
    // pointers wrap naturally because depth is a power of two; flags are registered from next count
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + addr_w'(1);
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + addr_w'(1);
            r_count <= w_count_nxt;
            r_empty <= w_count_nxt == '0;
            r_full  <= w_count_nxt == (addr_w+1)'(depth);
        end
    end
    fifo_mem #(.width(width), .depth(depth), .addr_w(addr_w)) u_mem (
        .clk(clk),
        .rst(rstn),
        .i_we(w_wr_acc),
        .i_waddr(r_wr_ptr),
        .i_wdata(data_in),
        .i_re(w_rd_acc),
        .i_raddr(r_rd_ptr),
        .o_rdata(data_out)
    );
endmodule

// File: tb/tb_fifo.sv
// tb_fifo: scenario tasks plus randomized traffic checked against a queue model
module tb_fifo;
    import fifo_pkg::*;
    logic clk = 0, rstn = 0, wr_en = 0, rd_en = 0;
    logic [fifo_width-1:0] data_in = '0, data_out;
    logic full, empty;
    int checks = 0, errors = 0;
    logic [fifo_width-1:0] q[$];
    logic [fifo_width-1:0] m_dout = '0;

    fifo dut (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .rd_en(rd_en),
        .data_in(data_in), .data_out(data_out), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // drive one cycle, update the queue model at the edge, leave #1 after the edge
    task automatic cycle(input logic w, input logic r, input logic [fifo_width-1:0] d);
        bit rd_ok, wr_ok;
        wr_en = w; rd_en = r; data_in = d;
        @(posedge clk);
        rd_ok = r && q.size() > 0;
        wr_ok = w && (q.size() < fifo_depth || rd_ok);
        if (rd_ok) m_dout = q.pop_front();
        if (wr_ok) q.push_back(d);
        #1;
        wr_en = 0; rd_en = 0; data_in = fifo_width'($urandom);
    endtask

    task automatic do_reset;
        rstn = 1; q.delete(); m_dout = '0;
        @(posedge clk); #1;
        rstn = 0;
    endtask

    task automatic test_reset;
        #2 rstn = 1;
        #1;
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || data_out !== '0) begin
            errors++; $display("FAIL reset_async got empty=%b full=%b dout=%h exp 1 0 00", empty, full, data_out);
        end
        @(posedge clk); #1;
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || data_out !== '0) begin
            errors++; $display("FAIL reset_hold got empty=%b full=%b dout=%h exp 1 0 00", empty, full, data_out);
        end
        rstn = 0;
    endtask

    task automatic test_write_drain;
        logic [fifo_width-1:0] a, b;
        logic [fifo_width-1:0] exp[4];
        a = fifo_width'($urandom); b = fifo_width'($urandom);
        if (b == a) b = ~a;
        exp = '{a, a, b, b};
        cycle(1, 0, a);
        checks++;
        if (empty !== 1'b0) begin errors++; $display("FAIL wd_not_empty got %b exp 0", empty); end
        cycle(1, 0, a);
        cycle(1, 0, b);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, '0);
            checks++;
            if (data_out !== exp[i] || empty !== (i >= 2)) begin
                errors++; $display("FAIL wd_read%0d got dout=%h empty=%b exp %h %b", i, data_out, empty, exp[i], i >= 2);
            end
        end
    endtask

    task automatic test_fill;
        for (int i = 1; i <= 8; i++) begin
            cycle(1, 0, fifo_width'(i));
            checks++;
            if (full !== (i == 8)) begin errors++; $display("FAIL fill_full%0d got %b exp %b", i, full, i == 8); end
        end
        cycle(1, 0, 8'h09);
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL fill_overflow_full got %b exp 1", full); end
        for (int i = 1; i <= 8; i++) begin
            cycle(0, 1, '0);
            checks++;
            if (data_out !== fifo_width'(i)) begin errors++; $display("FAIL fill_read%0d got %h exp %h", i, data_out, i); end
        end
        checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL fill_drained got empty=%b full=%b exp 1 0", empty, full); end
    endtask

    task automatic test_wrap;
        logic [fifo_width-1:0] v[5];
        do_reset();
        for (int i = 0; i < 5; i++) begin v[i] = fifo_width'($urandom); cycle(1, 0, v[i]); end
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, '0);
            checks++;
            if (data_out !== v[i]) begin errors++; $display("FAIL wrap_pre%0d got %h exp %h", i, data_out, v[i]); end
        end
        for (int i = 0; i < 7; i++) cycle(1, 0, fifo_width'(8'h10 + i));
        for (int i = 0; i < 7; i++) begin
            cycle(0, 1, '0);
            checks++;
            if (data_out !== fifo_width'(8'h10 + i)) begin errors++; $display("FAIL wrap_rd%0d got %h exp %h", i, data_out, 8'h10 + i); end
        end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b exp 1", empty); end
    endtask

    task automatic test_simul;
        logic [fifo_width-1:0] exp3[3];
        exp3 = '{8'd3, 8'd4, 8'd4};
        do_reset();
        for (int i = 1; i <= 3; i++) cycle(1, 0, fifo_width'(i));
        for (int i = 1; i <= 2; i++) begin
            cycle(1, 1, 8'd4);
            checks++;
            if (data_out !== fifo_width'(i) || empty !== 1'b0 || full !== 1'b0) begin
                errors++; $display("FAIL simul_mid%0d got dout=%h empty=%b full=%b exp %h 0 0", i, data_out, empty, full, i);
            end
        end
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, '0);
            checks++;
            if (data_out !== exp3[i] || empty !== (i == 2)) begin
                errors++; $display("FAIL simul_rest%0d got dout=%h empty=%b exp %h %b", i, data_out, empty, exp3[i], i == 2);
            end
        end
        cycle(1, 1, 8'h55);
        checks++;
        if (data_out !== 8'd4 || empty !== 1'b0) begin errors++; $display("FAIL simul_empty1 got dout=%h empty=%b exp 04 0", data_out, empty); end
        cycle(1, 1, 8'h55);
        checks++;
        if (data_out !== 8'h55 || empty !== 1'b0 || full !== 1'b0) begin
            errors++; $display("FAIL simul_empty2 got dout=%h empty=%b full=%b exp 55 0 0", data_out, empty, full);
        end
        cycle(0, 1, '0);
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL simul_empty3 got %b exp 1", empty); end
        for (int i = 0; i < 8; i++) cycle(1, 0, fifo_width'(8'h80 + i));
        cycle(1, 1, 8'h99);
        checks++;
        if (data_out !== 8'h80 || full !== 1'b1) begin errors++; $display("FAIL simul_full got dout=%h full=%b exp 80 1", data_out, full); end
        for (int i = 1; i <= 8; i++) begin
            cycle(0, 1, '0);
            checks++;
            if (data_out !== ((i == 8) ? 8'h99 : fifo_width'(8'h80 + i))) begin
                errors++; $display("FAIL simul_full_rd%0d got %h exp %h", i, data_out, (i == 8) ? 8'h99 : 8'h80 + i);
            end
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 0, fifo_width'($urandom));
        cycle(0, 1, '0);
        #3 rstn = 1; q.delete(); m_dout = '0;
        #1;
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || data_out !== '0) begin
            errors++; $display("FAIL rstmid_async got empty=%b full=%b dout=%h exp 1 0 00", empty, full, data_out);
        end
        @(posedge clk); #1;
        rstn = 0;
        cycle(1, 0, 8'h2A);
        cycle(0, 1, '0);
        checks++;
        if (data_out !== 8'h2A || empty !== 1'b1) begin
            errors++; $display("FAIL rstmid_after got dout=%h empty=%b exp 2a 1", data_out, empty);
        end
    endtask

    task automatic test_random;
        logic w, r;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            w = $urandom_range(0, 99) < ((i % 200) < 100 ? 75 : 30);
            r = $urandom_range(0, 99) < ((i % 200) < 100 ? 35 : 70);
            cycle(w, r, fifo_width'($urandom));
            checks++;
            if (data_out !== m_dout || empty !== (q.size() == 0) || full !== (q.size() == fifo_depth)) begin
                errors++;
                $display("FAIL random%0d got dout=%h empty=%b full=%b exp %h %b %b", i, data_out, empty, full,
                         m_dout, q.size() == 0, q.size() == fifo_depth);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_drain();
        test_fill();
        test_wrap();
        test_simul();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
